resp_collector: RTL and testbench
=================================

RESP_COLLECTOR -- requirements
Module: resp_collector

Interface
REQ-001: Parameter FIFO_DEPTH, default 4, entries per port queue; legal values 2, 4 or 8.
REQ-002: Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-003: c_clk  input  1  sole clock; all state updates on rising edge.
REQ-004: reset_n  input  1  asynchronous active-low reset; 0 = in reset.
REQ-005: in_dataP  input  32  port P data (P = 1..4) from the ALU output stage.
REQ-006: in_respP  input  2  port P response: 00 none, 01 good, 10 overflow/error, 11 illegal.
REQ-007: in_tagP  input  2  port P command tag.
REQ-008: rsp_vldP  output  1  port P queue head valid.
REQ-009: rsp_rdyP  input  1  port P consumer accepts head.
REQ-010: rsp_dataP / rsp_respP / rsp_tagP  output  32/2/2  port P queue head fields.
REQ-011: ovf_errP  output  1  sticky: a port P response was dropped because the queue was full.
REQ-012: ill_errP  output  1  sticky: port P received resp code 11.
REQ-013: cntP  output  4  current occupancy of port P queue, 0..FIFO_DEPTH.

Function
REQ-014: Each rising edge where in_respP is 01 or 10 SHALL count as exactly one new response for port P.
REQ-015: in_respP = 00 SHALL be ignored; in_dataP and in_tagP are don't-care in that cycle.
REQ-016: in_respP = 11 SHALL not be enqueued and SHALL set ill_errP on that edge.
REQ-017: Each port SHALL own an independent FIFO_DEPTH-entry queue of {resp, tag, data}, 36 bits per entry, in arrival order.
REQ-018: Enqueue latency SHALL be one edge: a response sampled at edge N gives rsp_vldP = 1 after edge N when the queue was empty.
REQ-019: rsp_vldP SHALL equal (cntP != 0), and the rsp_* fields SHALL present the oldest entry combinationally from storage.
REQ-020: A pop SHALL occur on an edge where rsp_vldP && rsp_rdyP; rsp_rdyP while the queue is empty SHALL have no effect.
REQ-021: rsp_vldP SHALL NOT depend combinationally on rsp_rdyP.
REQ-022: Push while full without a simultaneous pop SHALL drop the response, leave the queue and cntP unchanged, and set ovf_errP.
REQ-023: Push and pop on the same edge SHALL both succeed at any occupancy, including full, and cntP SHALL be unchanged.
REQ-024: Read and write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be derived from cntP, not from pointer equality alone.
REQ-025: ovf_errP and ill_errP SHALL clear only on reset.
REQ-026: The four ports SHALL be fully independent; simultaneous responses on all ports in one cycle SHALL all be accepted.

Reset
REQ-027: While reset_n = 0: cntP = 0, pointers = 0, rsp_vldP = 0, ovf_errP = 0 and ill_errP = 0, immediately (asynchronously).
REQ-028: Reset asserted mid-operation SHALL discard all queued entries; storage contents need not be cleared.
REQ-029: The first input sample SHALL be taken on the first rising edge after reset_n deasserts.

Structure
REQ-030: A shared package/include SHALL hold the response codes (NONE = 00, GOOD = 01, ERR = 10, ILL = 11), the entry width (36) and the default FIFO_DEPTH.
REQ-031: The per-port queue SHALL be a sub-module resp_fifo, instantiated four times; resp_collector holds only the decode, the sticky flags and the wiring.

Verification
REQ-032: After reset, port 1 receives resp 01, tag 2, data 0x12345678 on one edge -> rsp_vld1 = 1 next cycle, fields match, cnt1 = 1; pop -> cnt1 = 0.
REQ-033: Port 3 receives 5 consecutive GOOD responses (data 1..5) with rsp_rdy3 = 0 -> cnt3 = 4, ovf_err3 = 1, data 5 dropped; draining yields 1, 2, 3, 4 in order.
REQ-034: Port 2 is full with rsp_rdy2 = 1 and a push arrives on the same edge -> cnt2 stays 4, ovf_err2 = 0, new entry appears at the tail.
REQ-035: Port 4 receives in_resp4 = 11 -> no enqueue, cnt4 = 0, ill_err4 = 1 and it persists until reset_n = 0.
REQ-036: All four ports push together for 10 cycles with random rdy -> each port matches a scoreboard; reset_n is pulsed low mid-stream -> all cnt = 0 and rsp_vld = 0 with no clock edge.

Source files
------------

// File: rtl/resp_collector_pkg.sv
// resp_collector_pkg: response codes, entry width and default queue depth shared by the collector
package resp_collector_pkg;

    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_GOOD = 2'b01,
        RESP_ERR  = 2'b10,
        RESP_ILL  = 2'b11
    } resp_e;

    localparam int ENTRY_W            = 36;
    localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: per-port response queue with count-based full/empty and drop-on-full
module resp_fifo
    import resp_collector_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic               c_clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] entry,
    input  logic               pop,
    output logic               vld,
    output logic [ENTRY_W-1:0] head,
    output logic [3:0]         cnt,
    output logic               drop
);

    localparam int PW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               full;
    logic               do_pop;
    logic               do_push;

    assign full    = cnt == 4'(DEPTH);
    assign vld     = cnt != 4'd0;
    assign do_pop  = vld & pop;
    assign do_push = push & (!full | do_pop);
    assign drop    = push & full & !do_pop;
    assign head    = mem[rd_ptr];

    // pointers wrap naturally at the power-of-two depth; occupancy tracks push minus pop
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + 4'(do_push) - 4'(do_pop);
        end
    end

    // storage is not reset; discarded entries are unreachable once the pointers clear
    always_ff @(posedge c_clk) begin
        if (do_push) mem[wr_ptr] <= entry;
    end

endmodule

// File: rtl/resp_collector.sv
// resp_collector: decodes four ALU response ports into independent queues with sticky error flags
module resp_collector
    import resp_collector_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        c_clk,
    input  logic        reset_n,
    input  logic [31:0] in_data1,
    input  logic [31:0] in_data2,
    input  logic [31:0] in_data3,
    input  logic [31:0] in_data4,
    input  logic [1:0]  in_resp1,
    input  logic [1:0]  in_resp2,
    input  logic [1:0]  in_resp3,
    input  logic [1:0]  in_resp4,
    input  logic [1:0]  in_tag1,
    input  logic [1:0]  in_tag2,
    input  logic [1:0]  in_tag3,
    input  logic [1:0]  in_tag4,
    output logic        rsp_vld1,
    output logic        rsp_vld2,
    output logic        rsp_vld3,
    output logic        rsp_vld4,
    input  logic        rsp_rdy1,
    input  logic        rsp_rdy2,
    input  logic        rsp_rdy3,
    input  logic        rsp_rdy4,
    output logic [31:0] rsp_data1,
    output logic [31:0] rsp_data2,
    output logic [31:0] rsp_data3,
    output logic [31:0] rsp_data4,
    output logic [1:0]  rsp_resp1,
    output logic [1:0]  rsp_resp2,
    output logic [1:0]  rsp_resp3,
    output logic [1:0]  rsp_resp4,
    output logic [1:0]  rsp_tag1,
    output logic [1:0]  rsp_tag2,
    output logic [1:0]  rsp_tag3,
    output logic [1:0]  rsp_tag4,
    output logic        ovf_err1,
    output logic        ovf_err2,
    output logic        ovf_err3,
    output logic        ovf_err4,
    output logic        ill_err1,
    output logic        ill_err2,
    output logic        ill_err3,
    output logic        ill_err4,
    output logic [3:0]  cnt1,
    output logic [3:0]  cnt2,
    output logic [3:0]  cnt3,
    output logic [3:0]  cnt4
);

    logic [3:0][31:0]        dat;
    logic [3:0][1:0]         rsp;
    logic [3:0][1:0]         tg;
    logic [3:0]              rdy;
    logic [3:0]              vld;
    logic [3:0]              drop;
    logic [3:0]              ill_hit;
    logic [3:0]              ovf_q;
    logic [3:0]              ill_q;
    logic [3:0][ENTRY_W-1:0] head;
    logic [3:0][3:0]         cnt;

    assign dat = {in_data4, in_data3, in_data2, in_data1};
    assign rsp = {in_resp4, in_resp3, in_resp2, in_resp1};
    assign tg  = {in_tag4, in_tag3, in_tag2, in_tag1};
    assign rdy = {rsp_rdy4, rsp_rdy3, rsp_rdy2, rsp_rdy1};

    for (genvar i = 0; i < 4; i++) begin : g_port
        assign ill_hit[i] = rsp[i] == RESP_ILL;
        resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .c_clk   (c_clk),
            .reset_n (reset_n),
            .push    (rsp[i] == RESP_GOOD || rsp[i] == RESP_ERR),
            .entry   ({rsp[i], tg[i], dat[i]}),
            .pop     (rdy[i]),
            .vld     (vld[i]),
            .head    (head[i]),
            .cnt     (cnt[i]),
            .drop    (drop[i])
        );
    end

    // sticky overflow and illegal-code flags, cleared only by reset
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= '0;
            ill_q <= '0;
        end else begin
            ovf_q <= ovf_q | drop;
            ill_q <= ill_q | ill_hit;
        end
    end

    assign {rsp_vld4, rsp_vld3, rsp_vld2, rsp_vld1} = vld;
    assign {ovf_err4, ovf_err3, ovf_err2, ovf_err1} = ovf_q;
    assign {ill_err4, ill_err3, ill_err2, ill_err1} = ill_q;
    assign {rsp_resp1, rsp_tag1, rsp_data1} = head[0];
    assign {rsp_resp2, rsp_tag2, rsp_data2} = head[1];
    assign {rsp_resp3, rsp_tag3, rsp_data3} = head[2];
    assign {rsp_resp4, rsp_tag4, rsp_data4} = head[3];
    assign cnt1 = cnt[0];
    assign cnt2 = cnt[1];
    assign cnt3 = cnt[2];
    assign cnt4 = cnt[3];

endmodule

// File: tb/tb_resp_collector.sv
// tb_resp_collector: directed vector table plus scoreboarded random burst with async reset
module tb_resp_collector;

    logic            c_clk;
    logic            reset_n;
    logic [3:0][31:0] in_data;
    logic [3:0][1:0]  in_resp;
    logic [3:0][1:0]  in_tag;
    logic [3:0]       rsp_rdy;
    logic [3:0]       rsp_vld;
    logic [3:0][31:0] rsp_data;
    logic [3:0][1:0]  rsp_resp;
    logic [3:0][1:0]  rsp_tag;
    logic [3:0]       ovf_err;
    logic [3:0]       ill_err;
    logic [3:0][3:0]  cnt;

    int checks = 0;
    int errors = 0;

    resp_collector #(.FIFO_DEPTH(4)) dut (
        .c_clk(c_clk), .reset_n(reset_n),
        .in_data1(in_data[0]), .in_data2(in_data[1]), .in_data3(in_data[2]), .in_data4(in_data[3]),
        .in_resp1(in_resp[0]), .in_resp2(in_resp[1]), .in_resp3(in_resp[2]), .in_resp4(in_resp[3]),
        .in_tag1(in_tag[0]), .in_tag2(in_tag[1]), .in_tag3(in_tag[2]), .in_tag4(in_tag[3]),
        .rsp_vld1(rsp_vld[0]), .rsp_vld2(rsp_vld[1]), .rsp_vld3(rsp_vld[2]), .rsp_vld4(rsp_vld[3]),
        .rsp_rdy1(rsp_rdy[0]), .rsp_rdy2(rsp_rdy[1]), .rsp_rdy3(rsp_rdy[2]), .rsp_rdy4(rsp_rdy[3]),
        .rsp_data1(rsp_data[0]), .rsp_data2(rsp_data[1]), .rsp_data3(rsp_data[2]), .rsp_data4(rsp_data[3]),
        .rsp_resp1(rsp_resp[0]), .rsp_resp2(rsp_resp[1]), .rsp_resp3(rsp_resp[2]), .rsp_resp4(rsp_resp[3]),
        .rsp_tag1(rsp_tag[0]), .rsp_tag2(rsp_tag[1]), .rsp_tag3(rsp_tag[2]), .rsp_tag4(rsp_tag[3]),
        .ovf_err1(ovf_err[0]), .ovf_err2(ovf_err[1]), .ovf_err3(ovf_err[2]), .ovf_err4(ovf_err[3]),
        .ill_err1(ill_err[0]), .ill_err2(ill_err[1]), .ill_err3(ill_err[2]), .ill_err4(ill_err[3]),
        .cnt1(cnt[0]), .cnt2(cnt[1]), .cnt3(cnt[2]), .cnt4(cnt[3])
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    typedef struct {
        int          p;
        logic [1:0]  resp;
        logic [1:0]  tag;
        logic [31:0] data;
        logic        rdy;
        logic [3:0]  cnt;
        logic [1:0]  hresp;
        logic [1:0]  htag;
        logic [31:0] hdata;
        logic        ovf;
        logic        ill;
    } vec_t;

    vec_t vt[$];
    logic [35:0] sb [4][$];
    logic [3:0]  ovf_m;
    logic [3:0]  ill_m;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int p, input logic [1:0] resp, input logic [1:0] tag, input logic [31:0] data,
                       input logic rdy, input logic [3:0] c, input logic [1:0] hr, input logic [1:0] ht,
                       input logic [31:0] hd, input logic ovf, input logic ill);
        vec_t v;
        v.p = p; v.resp = resp; v.tag = tag; v.data = data; v.rdy = rdy; v.cnt = c;
        v.hresp = hr; v.htag = ht; v.hdata = hd; v.ovf = ovf; v.ill = ill;
        vt.push_back(v);
    endtask

    task automatic idle();
        in_data = '0;
        in_resp = '0;
        in_tag  = '0;
        rsp_rdy = '0;
    endtask

    task automatic chk_all_clear(input string tagname);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("%s cnt%0d", tagname, p + 1), 36'(cnt[p]), 36'd0);
            chk($sformatf("%s vld%0d", tagname, p + 1), 36'(rsp_vld[p]), 36'd0);
            chk($sformatf("%s ovf%0d", tagname, p + 1), 36'(ovf_err[p]), 36'd0);
            chk($sformatf("%s ill%0d", tagname, p + 1), 36'(ill_err[p]), 36'd0);
        end
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        #2;
        chk_all_clear("reset");

        // port 1 single good response, then pop, then pop on empty
        add(0, 2'b01, 2'd2, 32'h12345678, 1'b0, 4'd1, 2'b01, 2'd2, 32'h12345678, 1'b0, 1'b0);
        add(0, 2'b00, 2'd0, 32'h0, 1'b1, 4'd0, 2'b00, 2'd0, 32'h0, 1'b0, 1'b0);
        add(0, 2'b00, 2'd3, 32'hFFFF, 1'b1, 4'd0, 2'b00, 2'd0, 32'h0, 1'b0, 1'b0);
        // port 4 illegal code: no enqueue, sticky flag
        add(3, 2'b11, 2'd1, 32'hDEAD, 1'b0, 4'd0, 2'b00, 2'd0, 32'h0, 1'b0, 1'b1);
        add(3, 2'b00, 2'd0, 32'h0, 1'b1, 4'd0, 2'b00, 2'd0, 32'h0, 1'b0, 1'b1);
        // port 3 overflow: fifth response dropped, then ordered drain
        add(2, 2'b01, 2'd0, 32'd1, 1'b0, 4'd1, 2'b01, 2'd0, 32'd1, 1'b0, 1'b0);
        add(2, 2'b01, 2'd0, 32'd2, 1'b0, 4'd2, 2'b01, 2'd0, 32'd1, 1'b0, 1'b0);
        add(2, 2'b01, 2'd0, 32'd3, 1'b0, 4'd3, 2'b01, 2'd0, 32'd1, 1'b0, 1'b0);
        add(2, 2'b01, 2'd0, 32'd4, 1'b0, 4'd4, 2'b01, 2'd0, 32'd1, 1'b0, 1'b0);
        add(2, 2'b01, 2'd0, 32'd5, 1'b0, 4'd4, 2'b01, 2'd0, 32'd1, 1'b1, 1'b0);
        add(2, 2'b00, 2'd0, 32'd0, 1'b1, 4'd3, 2'b01, 2'd0, 32'd2, 1'b1, 1'b0);
        add(2, 2'b00, 2'd0, 32'd0, 1'b1, 4'd2, 2'b01, 2'd0, 32'd3, 1'b1, 1'b0);
        add(2, 2'b00, 2'd0, 32'd0, 1'b1, 4'd1, 2'b01, 2'd0, 32'd4, 1'b1, 1'b0);
        add(2, 2'b00, 2'd0, 32'd0, 1'b1, 4'd0, 2'b00, 2'd0, 32'd0, 1'b1, 1'b0);
        // port 2 fill to full, then push+pop while full, then drain
        add(1, 2'b10, 2'd3, 32'hA, 1'b0, 4'd1, 2'b10, 2'd3, 32'hA, 1'b0, 1'b0);
        add(1, 2'b01, 2'd0, 32'hB, 1'b0, 4'd2, 2'b10, 2'd3, 32'hA, 1'b0, 1'b0);
        add(1, 2'b01, 2'd1, 32'hC, 1'b0, 4'd3, 2'b10, 2'd3, 32'hA, 1'b0, 1'b0);
        add(1, 2'b01, 2'd2, 32'hD, 1'b0, 4'd4, 2'b10, 2'd3, 32'hA, 1'b0, 1'b0);
        add(1, 2'b01, 2'd3, 32'hE, 1'b1, 4'd4, 2'b01, 2'd0, 32'hB, 1'b0, 1'b0);
        add(1, 2'b00, 2'd0, 32'h0, 1'b1, 4'd3, 2'b01, 2'd1, 32'hC, 1'b0, 1'b0);
        add(1, 2'b00, 2'd0, 32'h0, 1'b1, 4'd2, 2'b01, 2'd2, 32'hD, 1'b0, 1'b0);
        add(1, 2'b00, 2'd0, 32'h0, 1'b1, 4'd1, 2'b01, 2'd3, 32'hE, 1'b0, 1'b0);
        add(1, 2'b00, 2'd0, 32'h0, 1'b1, 4'd0, 2'b00, 2'd0, 32'h0, 1'b0, 1'b0);

        @(negedge c_clk);
        reset_n = 1'b1;
        @(negedge c_clk);
        for (int i = 0; i < vt.size(); i++) begin
            idle();
            in_resp[vt[i].p] = vt[i].resp;
            in_tag[vt[i].p]  = vt[i].tag;
            in_data[vt[i].p] = vt[i].data;
            rsp_rdy[vt[i].p] = vt[i].rdy;
            @(negedge c_clk);
            chk($sformatf("v%0d cnt%0d", i, vt[i].p + 1), 36'(cnt[vt[i].p]), 36'(vt[i].cnt));
            chk($sformatf("v%0d vld%0d", i, vt[i].p + 1), 36'(rsp_vld[vt[i].p]), 36'(vt[i].cnt != 4'd0));
            chk($sformatf("v%0d ovf%0d", i, vt[i].p + 1), 36'(ovf_err[vt[i].p]), 36'(vt[i].ovf));
            chk($sformatf("v%0d ill%0d", i, vt[i].p + 1), 36'(ill_err[vt[i].p]), 36'(vt[i].ill));
            if (vt[i].cnt != 4'd0)
                chk($sformatf("v%0d head%0d", i, vt[i].p + 1),
                    {rsp_resp[vt[i].p], rsp_tag[vt[i].p], rsp_data[vt[i].p]},
                    {vt[i].hresp, vt[i].htag, vt[i].hdata});
        end
        idle();
        chk("ill4 persists", 36'(ill_err[3]), 36'd1);
        chk("ovf3 persists", 36'(ovf_err[2]), 36'd1);

        // reset clears the sticky flags
        reset_n = 1'b0;
        #1;
        chk_all_clear("pulse");
        @(negedge c_clk);
        reset_n = 1'b1;
        ovf_m = '0;
        ill_m = '0;

        // all ports active together against a scoreboard, reset pulsed mid-stream
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                #2;
                reset_n = 1'b0;
                #1;
                chk_all_clear("midrst");
                @(negedge c_clk);
                reset_n = 1'b1;
                for (int p = 0; p < 4; p++) sb[p].delete();
                ovf_m = '0;
                ill_m = '0;
            end
            for (int p = 0; p < 4; p++) begin
                logic pop_m;
                in_resp[p] = 2'($urandom_range(0, 3));
                in_tag[p]  = 2'($urandom_range(0, 3));
                in_data[p] = $urandom;
                rsp_rdy[p] = 1'($urandom_range(0, 1));
                pop_m = rsp_rdy[p] && sb[p].size() > 0;
                if (pop_m) void'(sb[p].pop_front());
                if (in_resp[p] == 2'b01 || in_resp[p] == 2'b10) begin
                    if (sb[p].size() < 4) sb[p].push_back({in_resp[p], in_tag[p], in_data[p]});
                    else ovf_m[p] = 1'b1;
                end
                if (in_resp[p] == 2'b11) ill_m[p] = 1'b1;
            end
            @(negedge c_clk);
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("r%0d cnt%0d", i, p + 1), 36'(cnt[p]), 36'(sb[p].size()));
                chk($sformatf("r%0d vld%0d", i, p + 1), 36'(rsp_vld[p]), 36'(sb[p].size() > 0));
                chk($sformatf("r%0d ovf%0d", i, p + 1), 36'(ovf_err[p]), 36'(ovf_m[p]));
                chk($sformatf("r%0d ill%0d", i, p + 1), 36'(ill_err[p]), 36'(ill_m[p]));
                if (sb[p].size() > 0)
                    chk($sformatf("r%0d head%0d", i, p + 1), {rsp_resp[p], rsp_tag[p], rsp_data[p]}, sb[p][0]);
            end
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
